// File: rtl/mul_issue_if.sv
// Operand and result valid/ready streams of the multiplier issue controller.
interface mul_issue_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [TAG_W-1:0]   in_tag;
    logic               res_valid;
    logic               res_ready;
    logic [2*WIDTH-1:0] res_product;
    logic [TAG_W-1:0]   res_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, res_ready,
        input  in_ready, res_valid, res_product, res_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, res_ready,
        output in_ready, res_valid, res_product, res_tag
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue controller for the iterative multiplier: FIFO-buffered jobs,
// single-cycle launch, per-job product from the cumulative register.
module mul_issue_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SUBDIV_SIZE = 4,
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mul_issue_if.slave         io,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_op_a,
    output logic [WIDTH-1:0]   mul_op_b,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic               mul_done,
    output logic               busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2*WIDTH + TAG_W;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    if ((WIDTH % SUBDIV_SIZE) != 0 || DEPTH < 2) begin : g_bad_cfg
        $error("mul_issue_ctrl: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

    state_t state_q, state_d;

    logic [EW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic               full, empty, push, pop, capture;
    logic [EW-1:0]      head;
    logic [TAG_W-1:0]   tag_q;
    logic [2*WIDTH-1:0] base;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = io.in_valid && !full;
    assign head  = mem[rd_ptr];

    assign io.in_ready = !full;
    assign mul_start   = (state_q == LAUNCH);
    assign busy = (state_q != IDLE) || !empty || io.res_valid;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = LAUNCH;
                end
            end
            // mul_done may still be high from the previous job here
            LAUNCH: state_d = BUSY;
            BUSY: begin
                if (mul_done && (!io.res_valid || io.res_ready)) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {io.in_a, io.in_b, io.in_tag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_op_a <= '0;
            mul_op_b <= '0;
            tag_q    <= '0;
            base     <= '0;
        end else begin
            if (pop) begin
                mul_op_a <= head[EW-1 -: WIDTH];
                mul_op_b <= head[TAG_W +: WIDTH];
                tag_q    <= head[TAG_W-1:0];
            end
            if (state_q == LAUNCH) base <= mul_product;
        end
    end

    // The multiplier never clears its product, so subtract the launch snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.res_valid   <= 1'b0;
            io.res_product <= '0;
            io.res_tag     <= '0;
        end else if (capture) begin
            io.res_valid   <= 1'b1;
            io.res_product <= mul_product - base;
            io.res_tag     <= tag_q;
        end else if (io.res_ready) begin
            io.res_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with an accumulating multiplier model.
module tb_mul_issue_ctrl;
    localparam int W  = 8;
    localparam int TW = 4;
    localparam int N  = 4;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [TW-1:0]  t;
        logic [2*W-1:0] p;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] p;
        logic [TW-1:0]  t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_issue_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    logic           mul_start;
    logic [W-1:0]   mul_op_a, mul_op_b;
    logic [2*W-1:0] mul_product;
    logic           mul_done;
    logic           busy;

    mul_issue_ctrl #(.WIDTH(W), .SUBDIV_SIZE(4), .DEPTH(4), .TAG_W(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .io          (bus.slave),
        .mul_start   (mul_start),
        .mul_op_a    (mul_op_a),
        .mul_op_b    (mul_op_b),
        .mul_product (mul_product),
        .mul_done    (mul_done),
        .busy        (busy)
    );

    // Multiplier model: product accumulates, done visible N cycles after start
    logic [2*W-1:0] m_prod = '0;
    logic           m_done = 1'b0;
    int             m_cnt = 0;
    logic           pre_en = 1'b0;
    logic [2*W-1:0] pre_val = '0;

    always @(posedge clk) begin
        if (pre_en) begin
            m_prod <= pre_val;
        end else if (mul_start) begin
            m_done <= 1'b0;
            m_cnt  <= N - 1;
        end else if (m_cnt == 1) begin
            m_prod <= m_prod + 16'(mul_op_a) * 16'(mul_op_b);
            m_done <= 1'b1;
            m_cnt  <= 0;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign mul_product = m_prod;
    assign mul_done    = m_done;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    exp_t expq[$];
    int   start_q[$];
    int   res_cyc = 0;
    logic prev_start = 1'b0;
    exp_t mon_e;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mul_start) begin
                start_q.push_back(cyc);
                chk("start_gap", {31'd0, prev_start}, 32'd0);
            end
            prev_start = mul_start;
            if (bus.res_valid && bus.res_ready) begin
                res_cyc = cyc;
                if (expq.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    mon_e = expq.pop_front();
                    chk("res_product", 32'(bus.res_product), 32'(mon_e.p));
                    chk("res_tag", 32'(bus.res_tag), 32'(mon_e.t));
                end
            end
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] t, output int acc);
        bit ok = 0;
        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = t;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok  = 1;
                acc = cyc;
                break;
            end
        end
        chk("push_accept", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (expq.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("drain", {31'd0, ok}, 32'd1);
    endtask

    vec_t vt[6];
    int   acc, s0;

    initial begin
        vt[0] = '{8'hFF, 8'hFF, 4'd3, 16'hFE01};
        vt[1] = '{8'h03, 8'h05, 4'd1, 16'h000F};
        vt[2] = '{8'h02, 8'h07, 4'd2, 16'h000E};
        vt[3] = '{8'h00, 8'hAB, 4'd4, 16'h0000};
        vt[4] = '{8'h80, 8'h02, 4'd5, 16'h0100};
        vt[5] = '{8'h12, 8'h34, 4'd6, 16'h03A8};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.res_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_product", 32'(bus.res_product), 32'd0);
        chk("rst_res_tag", 32'(bus.res_tag), 32'd0);
        chk("rst_mul_start", {31'd0, mul_start}, 32'd0);
        chk("rst_op_a", 32'(mul_op_a), 32'd0);
        chk("rst_op_b", 32'(mul_op_b), 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_no_start", 32'(start_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Isolated jobs: product, tag, and latency of each
        foreach (vt[i]) begin
            s0 = start_q.size();
            expq.push_back('{vt[i].p, vt[i].t});
            push(vt[i].a, vt[i].b, vt[i].t, acc);
            wait_drain(60);
            chk("single_start_cnt", 32'(start_q.size() - s0), 32'd1);
            chk("launch_cycle", 32'(start_q[start_q.size()-1] - acc), 32'd2);
            chk("res_cycle", 32'(res_cyc - acc), 32'd7);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // Product register wraps through 2^16
        pre_val = 16'hFFF0;
        pre_en  = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
        expq.push_back('{16'h0015, 4'd9});
        push(8'd3, 8'd7, 4'd9, acc);
        wait_drain(60);
        @(posedge clk);
        #1;

        // Back-to-back jobs with the result stream always ready
        start_q.delete();
        expq.push_back('{16'h0121, 4'd1});
        expq.push_back('{16'h00F0, 4'd2});
        expq.push_back('{16'h01FC, 4'd3});
        expq.push_back('{16'h003F, 4'd4});
        push(8'h11, 8'h11, 4'd1, acc);
        push(8'h0F, 8'h10, 4'd2, acc);
        push(8'hFE, 8'h02, 4'd3, acc);
        push(8'h07, 8'h09, 4'd4, acc);
        wait_drain(200);
        chk("b2b_start_cnt", 32'(start_q.size()), 32'd4);
        for (int k = 1; k < 4; k++)
            chk("b2b_spacing", 32'(start_q[k] - start_q[k-1]), 32'd6);
        @(posedge clk);
        #1;

        // Backpressure: one result held, one job parked, FIFO full
        bus.res_ready = 1'b0;
        start_q.delete();
        for (int k = 0; k < 6; k++)
            expq.push_back('{16'(k + 2) * 16'(k + 10), 4'(k + 8)});
        for (int k = 0; k < 6; k++)
            push(8'(k + 2), 8'(k + 10), 4'(k + 8), acc);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("bp_held_product", 32'(bus.res_product), 32'd20);
        chk("bp_held_tag", 32'(bus.res_tag), 32'd8);
        chk("bp_mul_done", {31'd0, mul_done}, 32'd1);
        chk("bp_start_cnt", 32'(start_q.size()), 32'd2);
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        wait_drain(300);
        chk("bp_total_starts", 32'(start_q.size()), 32'd6);
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        chk("bp_busy_after", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // Reset two cycles after LAUNCH drops the in-flight job
        start_q.delete();
        push(8'd4, 8'd4, 4'd5, acc);
        for (int i = 0; i < 20 && start_q.size() == 0; i++)
            @(negedge clk);
        chk("mid_launch_seen", 32'(start_q.size()), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_op_a", 32'(mul_op_a), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_rst_quiet", {31'd0, bus.res_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        expq.push_back('{16'h0051, 4'hA});
        push(8'd9, 8'd9, 4'hA, acc);
        wait_drain(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Issue controller placed directly upstream of the iterative subdivided multiplier. It accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. It launches the multiplier one job at a time with a single-cycle start pulse, holds the operands stable for the whole job, and returns each product with its tag on a valid/ready result stream. The multiplier's product register accumulates across jobs and is never cleared by start, so this block converts the cumulative value into a per-job product.

## Interface
- WIDTH, 8, operand width; must equal the multiplier's WIDTH.
- SUBDIV_SIZE, 4, multiplier chunk size. WIDTH/SUBDIV_SIZE must be a power of two, at least 2.
- DEPTH, 4, input FIFO entries; power of two, at least 2.
- TAG_W, 4, width of the caller tag passed through with each job.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full.
- in_a / in_b  in  WIDTH  operands.
- in_tag  in  TAG_W  caller tag.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_product  out  2*WIDTH  per-job product.
- res_tag  out  TAG_W  tag of the job.
- mul_start  out  1  single-cycle launch pulse to the multiplier.
- mul_op_a / mul_op_b  out  WIDTH  operands to the multiplier.
- mul_product  in  2*WIDTH  cumulative product from the multiplier.
- mul_done  in  1  multiplier done flag.
- busy  out  1  state is not IDLE, or FIFO is non-empty, or res_valid is high.

## Operation
- N = (WIDTH/SUBDIV_SIZE)^2 is the multiplier cycles per job.
- FIFO:
  - Push on in_valid & in_ready; in_ready = !full.
  - A push and a pop in the same cycle are both legal when full: pop frees the slot, but in_ready is still driven from registered full, so no push occurs that cycle.
  - Pointers wrap modulo DEPTH. Results are delivered in order.
- IDLE: if the FIFO is non-empty, pop the head into the op_a/op_b/tag registers and go to LAUNCH. Otherwise stay.
- LAUNCH:
  - mul_start = 1 for exactly this cycle.
  - base <= mul_product, capturing the total before this job's first term is added.
  - Go to BUSY. mul_done is ignored in this state, because it may still be high from the previous job.
- BUSY:
  - Wait for mul_done = 1.
  - When done, and the result register is free (!res_valid or res_ready this cycle):
    - res_product <= mul_product - base, modulo 2^(2*WIDTH);
    - res_tag <= tag;
    - res_valid <= 1;
    - go to IDLE.
  - If done but the result register is occupied, stay in BUSY. mul_done stays high because no new start is issued.
- mul_op_a/mul_op_b are driven continuously from the operand registers. They change only at the IDLE pop, never between LAUNCH and capture.
- res_valid clears on res_ready unless a new capture happens the same cycle.
- Reset, asynchronous, including mid-job:
  - state = IDLE; FIFO empty;
  - res_valid = 0, res_product = 0, res_tag = 0;
  - mul_start = 0, mul_op_a = mul_op_b = 0;
  - base = 0; busy = 0; in_ready = 1 when rst_n is released.
  - The in-flight job is discarded. No partial result is emitted.

## Timing
- Multiplier contract: start sampled at cycle t; mul_done = 1 and mul_product final are visible at cycle t+N.
- Single job: accepted at cycle 0, popped at cycle 1, LAUNCH at cycle 2, captured at cycle 2+N, res_valid at cycle 3+N.
- Steady-state throughput with res_ready = 1: one result every N+2 cycles.
- mul_start is never high in two consecutive cycles. It is never high in any cycle other than LAUNCH.

## Test plan
All scenarios use WIDTH=8, SUBDIV_SIZE=4, N=4, and a multiplier model that keeps its cumulative product.
- Reset: hold rst_n low, then release -> all outputs zero, in_ready = 1, busy = 0, mul_start never pulses.
- Single job: 0xFF × 0xFF, tag 3, accepted at cycle 0 -> res_valid at cycle 7, res_product 0xFE01, res_tag 3, exactly one mul_start pulse at cycle 2.
- Accumulation: 3 × 5 then 2 × 7 -> results 0x000F then 0x000E, not 0x001D. Preload the model's product with 0xFFF0, then run 3 × 7 -> 0x0015 via modular subtraction.
- Back-to-back: push 4 jobs with res_ready = 1 -> mul_start pulses every 6 cycles, results in push order with matching tags.
- Backpressure: res_ready = 0, push 6 jobs -> in_ready falls after DEPTH plus the in-flight jobs. One result is held and a second job waits in BUSY with mul_done high. After raising res_ready, all 6 results arrive in order and none is lost.
- Reset mid-job: assert rst_n two cycles after LAUNCH -> no res_valid, FIFO empty. A new job 9 × 9 after release returns 0x0051.
